drive_calc_sched: RTL



---
 rtl/drive_calc_sched_if.sv | 24 ++
 rtl/drive_calc_sched.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/drive_calc_sched_if.sv
// Request/result bundle for the assist-current sequencer.
// master: sensor-conditioning side (drives the request and snapshot data).
// slave:  the sequencer (returns busy and the target current).
interface drive_calc_sched_if;
    logic        start;
    logic [11:0] avg_torque;
    logic [4:0]  cadence;
    logic        not_pedaling;
    logic [12:0] incline;
    logic [2:0]  scale;
    logic        busy;
    logic [11:0] target_curr;
    logic        curr_vld;

    modport master (
        output start, avg_torque, cadence, not_pedaling, incline, scale,
        input  busy, target_curr, curr_vld
    );

    modport slave (
        input  start, avg_torque, cadence, not_pedaling, incline, scale,
        output busy, target_curr, curr_vld
    );
endinterface

// File: rtl/drive_calc_sched.sv
// drive_calc_sched: multi-cycle assist-current calculation.
// Snapshot -> factor prep -> three passes through one shared multiplier ->
// saturated 12-bit target current with a one-cycle valid strobe.
// Optional feature macro: DRIVE_SCHED_PEND_EN (remember one start that
// arrives while busy and run it as soon as the sequencer is idle again).
module drive_calc_sched (
    input  logic                      clk,
    input  logic                      rst_n,
    drive_calc_sched_if.slave         bus
);
    typedef enum logic [2:0] {IDLE, PREP, MUL1, MUL2, MUL3, DONE} state_t;

    state_t state, state_nxt;

    // snapshot registers
    logic [11:0] snap_torque;
    logic [4:0]  snap_cad;
    logic        snap_np;
    logic [12:0] snap_inc;
    logic [2:0]  snap_scale;

    // registered factors
    logic [8:0]  incline_lim;
    logic [5:0]  cadence_factor;
    logic [11:0] torque_pos;

    // factor combinational values
    logic signed [9:0]  incline_sat;
    logic signed [10:0] incline_factor;
    logic [8:0]         incline_lim_c;
    logic [5:0]         cadence_factor_c;
    logic [11:0]        torque_pos_c;

    // shared multiplier; first operand is 27 bits because the last pass
    // multiplies the full 27-bit result of the cadence pass
    logic [29:0] prod;
    logic [26:0] mul_a;
    logic [8:0]  mul_b;
    logic [35:0] mul_p;

    logic capture;
    logic pending;

`ifdef DRIVE_SCHED_PEND_EN
    // one-deep memory of starts seen while busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pending <= 1'b0;
        else if (capture)
            pending <= 1'b0;
        else if (bus.start && state != IDLE)
            pending <= 1'b1;
    end
`else
    assign pending = 1'b0;
`endif

    assign capture  = (state == IDLE) && (bus.start || pending);
    assign bus.busy = (state != IDLE);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // fixed-length sequence; only IDLE waits on anything
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (capture) state_nxt = PREP;
            PREP:    state_nxt = MUL1;
            MUL1:    state_nxt = MUL2;
            MUL2:    state_nxt = MUL3;
            MUL3:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // capture the live inputs once per accepted request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_torque <= '0;
            snap_cad    <= '0;
            snap_np     <= 1'b0;
            snap_inc    <= '0;
            snap_scale  <= '0;
        end else if (capture) begin
            snap_torque <= bus.avg_torque;
            snap_cad    <= bus.cadence;
            snap_np     <= bus.not_pedaling;
            snap_inc    <= bus.incline;
            snap_scale  <= bus.scale;
        end
    end

    // factor derivation from the snapshot
    always_comb begin
        if ($signed(snap_inc) > 13'sd511)
            incline_sat = 10'sd511;
        else if ($signed(snap_inc) < -13'sd512)
            incline_sat = -10'sd512;
        else
            incline_sat = $signed(snap_inc[9:0]);

        incline_factor = {incline_sat[9], incline_sat} + 11'sd256;

        if (incline_factor[10])
            incline_lim_c = 9'd0;
        else if (incline_factor[9])
            incline_lim_c = 9'd511;
        else
            incline_lim_c = incline_factor[8:0];

        cadence_factor_c = (snap_cad > 5'd1) ? ({1'b0, snap_cad} + 6'd32) : 6'd0;
        torque_pos_c     = (snap_torque >= 12'h380) ? (snap_torque - 12'h380) : 12'd0;
    end

    // register the factors in PREP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            incline_lim    <= '0;
            cadence_factor <= '0;
            torque_pos     <= '0;
        end else if (state == PREP) begin
            incline_lim    <= incline_lim_c;
            cadence_factor <= cadence_factor_c;
            torque_pos     <= torque_pos_c;
        end
    end

    // operand mux for the single multiplier
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            MUL1: begin
                mul_a = {15'd0, torque_pos};
                mul_b = incline_lim;
            end
            MUL2: begin
                mul_a = prod[26:0];
                mul_b = {3'd0, cadence_factor};
            end
            MUL3: begin
                mul_a = prod[26:0];
                mul_b = {6'd0, snap_scale};
            end
            default: ;
        endcase
    end

    assign mul_p = mul_a * mul_b;

    // accumulate the running product across the three passes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prod <= '0;
        else if (state == MUL1 || state == MUL2 || state == MUL3)
            prod <= mul_p[29:0];
    end

    // publish the saturated result with a one-cycle strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.target_curr <= '0;
            bus.curr_vld    <= 1'b0;
        end else begin
            bus.curr_vld <= (state == DONE);
            if (state == DONE) begin
                if (snap_np)
                    bus.target_curr <= 12'h000;
                else if (prod[29:27] != 3'd0)
                    bus.target_curr <= 12'hFFF;
                else
                    bus.target_curr <= prod[26:15];
            end
        end
    end
endmodule
